// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard unit and the E-stage forwarding muxes.
// Optional feature macro used by hazard_ctrl: HAZARD_PERF_CNT_EN.
package hazard_pkg;

  // Select encoding consumed by the srcA/srcB forwarding muxes
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // register-file read (RD1E/RD2E)
    FWD_WB  = 2'b01,  // resultW from writeback
    FWD_MEM = 2'b10   // aluresultM from memory stage
  } fwd_sel_t;

  // Hazard FSM: normal flow or holding E for a multi-cycle MDU op
  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
// Handshake: there is no valid/ready pair; every input is sampled every cycle
// and every output is meaningful every cycle. The pipeline (master) drives the
// register indices and E/M-stage status; the hazard unit (slave) returns the
// forward selects and the stall/flush controls in the same cycle.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  import hazard_pkg::*;

  logic [REG_AW-1:0] rs1D;
  logic [REG_AW-1:0] rs2D;
  logic [REG_AW-1:0] rdE;
  logic [REG_AW-1:0] rdM;
  logic              regwriteE;
  logic              regwriteM;
  logic              loadE;
  logic              pcsrcE;
  logic              mdu_startE;
  fwd_sel_t          forwardaE;
  fwd_sel_t          forwardbE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              flushD;
  logic              flushE;
  logic              flushM;
  logic              mdu_busy;

  modport master (
    output rs1D, rs2D, rdE, rdM, regwriteE, regwriteM, loadE, pcsrcE, mdu_startE,
    input  forwardaE, forwardbE, stallF, stallD, stallE, flushD, flushE, flushM,
           mdu_busy
  );

  modport slave (
    input  rs1D, rs2D, rdE, rdM, regwriteE, regwriteM, loadE, pcsrcE, mdu_startE,
    output forwardaE, forwardbE, stallF, stallD, stallE, flushD, flushE, flushM,
           mdu_busy
  );

endinterface

// File: rtl/hazard_ctrl_fwd_cmp.sv
// D-stage forwarding comparator for one source operand.
// A match against the E-stage writer wins over the M-stage writer because
// the E instruction is younger and holds the most recent value of the register.
module hazard_fwd_cmp
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic              regwrite_e_i,
  input  logic              regwrite_m_i,
  output fwd_sel_t          sel_o
);

  // x0 never forwards; E writer has priority over M writer
  always_comb begin
    sel_o = FWD_RF;
    if ((src_i != '0) && regwrite_e_i && (src_i == rd_e_i)) begin
      sel_o = FWD_MEM;
    end else if ((src_i != '0) && regwrite_m_i && (src_i == rd_m_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32 core: registered forward selects for E,
// load-use stall, branch flush and fixed-latency MDU hold.
// Optional feature: define HAZARD_PERF_CNT_EN to add stall_cnt/flush_cnt
// performance counters; without it the counters and their ports are absent.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int MDU_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int CNT_W = $clog2(MDU_LAT);

  hz_state_t         state_q;
  logic [CNT_W-1:0]  cnt_q;
  fwd_sel_t          fwd_a_d;
  fwd_sel_t          fwd_b_d;
  fwd_sel_t          fwd_a_q;
  fwd_sel_t          fwd_b_q;
  logic              in_wait;
  logic              lu;
  logic              br;
  logic              stall_f;
  logic              stall_e;
  logic              flush_d;
  logic              flush_e;
  logic              flush_m;

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
    .src_i       (hz.rs1D),
    .rd_e_i      (hz.rdE),
    .rd_m_i      (hz.rdM),
    .regwrite_e_i(hz.regwriteE),
    .regwrite_m_i(hz.regwriteM),
    .sel_o       (fwd_a_d)
  );

  hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
    .src_i       (hz.rs2D),
    .rd_e_i      (hz.rdE),
    .rd_m_i      (hz.rdM),
    .regwrite_e_i(hz.regwriteE),
    .regwrite_m_i(hz.regwriteM),
    .sel_o       (fwd_b_d)
  );

  // Zero-latency controls; priority MDU_WAIT > taken branch > load-use
  always_comb begin
    in_wait = (state_q == MDU_WAIT);
    lu      = hz.loadE && (hz.rdE != '0) &&
              ((hz.rs1D == hz.rdE) || (hz.rs2D == hz.rdE));
    br      = !in_wait && hz.pcsrcE;
    stall_f = in_wait || (!br && lu);
    stall_e = in_wait;
    flush_d = br;
    flush_e = br || (!in_wait && lu);
    flush_m = in_wait;
  end

  assign hz.stallF    = stall_f;
  assign hz.stallD    = stall_f;
  assign hz.stallE    = stall_e;
  assign hz.flushD    = flush_d;
  assign hz.flushE    = flush_e;
  assign hz.flushM    = flush_m;
  assign hz.mdu_busy  = in_wait;
  assign hz.forwardaE = fwd_a_q;
  assign hz.forwardbE = fwd_b_q;

  // MDU hold FSM: the start cycle plus MDU_LAT-1 wait cycles keep the op in E
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (hz.mdu_startE) begin
            state_q <= MDU_WAIT;
            cnt_q   <= CNT_W'(MDU_LAT - 2);
          end
        end
        MDU_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Forward selects move D->E with the instruction: bubble clears, stall holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (flush_e) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (!stall_e) begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // Free-running event counters, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f) stall_cnt <= stall_cnt + 32'd1;
      if (flush_d) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed cases followed by randomized traffic,
// compared cycle by cycle against a behavioural model through a queue.
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int MDU_LAT = 4;
`ifdef HAZARD_PERF_CNT_EN
  localparam int W = 11 + 64;
`else
  localparam int W = 11;
`endif

  logic clk;
  logic rst_n;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  hazard_ctrl_if #(.REG_AW(5)) tb_if ();

  hazard_ctrl #(.REG_AW(5), .MDU_LAT(MDU_LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .hz   (tb_if)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  logic         mon_en;
  int           n_checks;
  int           n_errors;

  // ---------------- reference model ----------------
  int           m_fa, m_fb;        // select presented in E this cycle
  int           rem;               // MDU wait cycles still to come (incl. this one)
  int unsigned  m_scnt, m_fcnt;
  logic [4:0]   p_rs1, p_rs2, p_rde, p_rdm;
  logic         p_we, p_wm, p_ld, p_pc, p_md;
  logic         e_sf, e_sd, e_se, e_fd, e_fe, e_fm;

  function automatic int fwd_of(input logic [4:0] src);
    if (src != 0 && p_we && src == p_rde) return 2;
    if (src != 0 && p_wm && src == p_rdm) return 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_fa = 0; m_fb = 0; rem = 0; m_scnt = 0; m_fcnt = 0;
    p_rs1 = 0; p_rs2 = 0; p_rde = 0; p_rdm = 0;
    p_we = 0; p_wm = 0; p_ld = 0; p_pc = 0; p_md = 0;
    e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0;
  endfunction

  // Effect of one clock edge, using the cycle that just ended
  function automatic void model_edge();
    if (e_fe) begin
      m_fa = 0; m_fb = 0;
    end else if (!e_se) begin
      m_fa = fwd_of(p_rs1); m_fb = fwd_of(p_rs2);
    end
    if (e_sf) m_scnt = m_scnt + 1;
    if (e_fd) m_fcnt = m_fcnt + 1;
    if (rem > 0) rem = rem - 1;
    else if (p_md) rem = MDU_LAT - 1;
  endfunction

  // Combinational controls for the current cycle
  function automatic void model_comb();
    logic lu;
    lu = p_ld && p_rde != 0 && (p_rs1 == p_rde || p_rs2 == p_rde);
    e_sf = 0; e_sd = 0; e_se = 0; e_fd = 0; e_fe = 0; e_fm = 0;
    if (rem > 0) begin
      e_sf = 1; e_sd = 1; e_se = 1; e_fm = 1;
    end else if (p_pc) begin
      e_fd = 1; e_fe = 1;
    end else if (lu) begin
      e_sf = 1; e_sd = 1; e_fe = 1;
    end
  endfunction

  function automatic logic [W-1:0] model_vec();
    logic [W-1:0] v;
    v = {2'(m_fa), 2'(m_fb), e_sf, e_sd, e_se, e_fd, e_fe, e_fm, (rem > 0)
`ifdef HAZARD_PERF_CNT_EN
         , 32'(m_scnt), 32'(m_fcnt)
`endif
        };
    return v;
  endfunction

  function automatic logic [W-1:0] dut_vec();
    logic [W-1:0] v;
    v = {tb_if.forwardaE, tb_if.forwardbE, tb_if.stallF, tb_if.stallD,
         tb_if.stallE, tb_if.flushD, tb_if.flushE, tb_if.flushM, tb_if.mdu_busy
`ifdef HAZARD_PERF_CNT_EN
         , stall_cnt, flush_cnt
`endif
        };
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic [4:0] r1, input logic [4:0] r2,
                      input logic [4:0] re, input logic [4:0] rm,
                      input logic we, input logic wm, input logic ld,
                      input logic pc, input logic md_req);
    logic md;
    @(posedge clk);
    #1;
    model_edge();
    md = md_req && (rem == 0);   // an MDU op only starts from normal flow
    tb_if.rs1D = r1; tb_if.rs2D = r2; tb_if.rdE = re; tb_if.rdM = rm;
    tb_if.regwriteE = we; tb_if.regwriteM = wm; tb_if.loadE = ld;
    tb_if.pcsrcE = pc; tb_if.mdu_startE = md;
    p_rs1 = r1; p_rs2 = r2; p_rde = re; p_rdm = rm;
    p_we = we; p_wm = wm; p_ld = ld; p_pc = pc; p_md = md;
    model_comb();
    exp_q.push_back(model_vec());
  endtask

  task automatic idle();
    step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en && exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = dut_vec();
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_errors++;
        $display("FAIL cycle_outputs: got %h expected %h (t=%0t)", mon_act, mon_exp, $time);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] a, b, c, d;
    logic       we, wm, ld, pc, md;

    n_checks = 0;
    n_errors = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    tb_if.rs1D = 0; tb_if.rs2D = 0; tb_if.rdE = 0; tb_if.rdM = 0;
    tb_if.regwriteE = 0; tb_if.regwriteM = 0; tb_if.loadE = 0;
    tb_if.pcsrcE = 0; tb_if.mdu_startE = 0;
    model_reset();

    #3;
    chk("reset_state", 80'(dut_vec()), 80'(0));
    #9;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // MDU op: three held cycles, normal flow on the fourth
    step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #2 chk("mdu_start_not_busy", 80'(tb_if.mdu_busy), 80'(0));
    for (int i = 0; i < 3; i++) begin
      idle();
      #2 chk("mdu_hold_stallE", 80'({tb_if.stallE, tb_if.flushM, tb_if.mdu_busy}), 80'(3'b111));
    end
    idle();
    #2 chk("mdu_done", 80'({tb_if.stallE, tb_if.mdu_busy}), 80'(0));
`ifdef HAZARD_PERF_CNT_EN
    chk("mdu_stall_cnt", 80'(stall_cnt), 80'(3));
`endif

    // EX->EX forward on rs1
    step(5'd5, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 chk("ex_ex_no_stall", 80'(tb_if.stallF), 80'(0));
    idle();
    #2 chk("ex_ex_fwda", 80'(tb_if.forwardaE), 80'(2'b10));

    // MEM->EX forward on rs2
    step(5'd0, 5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    #2 chk("mem_ex_fwdb", 80'(tb_if.forwardbE), 80'(2'b01));

    // Both stages write the same register: E wins; x0 never forwards
    step(5'd9, 5'd0, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    #2 chk("both_match_fwda", 80'(tb_if.forwardaE), 80'(2'b10));
    step(5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    #2 chk("x0_no_fwd", 80'(tb_if.forwardaE), 80'(2'b00));

    // Load-use: one stall cycle, bubble, then forward from W
    step(5'd4, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #2 chk("lu_controls", 80'({tb_if.stallF, tb_if.stallD, tb_if.flushE}), 80'(3'b111));
    step(5'd4, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 chk("lu_bubble_fwda", 80'(tb_if.forwardaE), 80'(2'b00));
    chk("lu_released", 80'(tb_if.stallF), 80'(0));
    idle();
    #2 chk("lu_fwda_wb", 80'(tb_if.forwardaE), 80'(2'b01));

    // Branch and load-use together: branch wins
    step(5'd4, 5'd0, 5'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #2 chk("br_lu_controls", 80'({tb_if.flushD, tb_if.flushE, tb_if.stallF, tb_if.stallD}), 80'(4'b1100));
    idle();
    #2 chk("br_fwda_cleared", 80'(tb_if.forwardaE), 80'(2'b00));

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a  = 5'($urandom_range(0, 7));
      b  = 5'($urandom_range(0, 7));
      c  = 5'($urandom_range(0, 7));
      d  = 5'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wm = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 3) == 0);
      md = ($urandom_range(0, 15) == 0);
      pc = !md && ($urandom_range(0, 7) == 0);
      step(a, b, c, d, we, wm, ld, pc, md);
    end

    // Reset in the middle of an MDU hold drops the op
    idle();
    step(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    #2 chk("pre_reset_busy", 80'(tb_if.mdu_busy), 80'(1));
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    exp_q.delete();
    rst_n = 1'b0;
    #1 chk("mid_wait_reset", 80'(dut_vec()), 80'(0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    idle();
    #2 chk("after_reset_run", 80'(tb_if.mdu_busy), 80'(0));

    for (int i = 0; i < 300; i++) begin
      a  = 5'($urandom_range(0, 7));
      b  = 5'($urandom_range(0, 7));
      c  = 5'($urandom_range(0, 7));
      d  = 5'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      wm = 1'($urandom_range(0, 1));
      ld = ($urandom_range(0, 2) == 0);
      md = ($urandom_range(0, 9) == 0);
      pc = !md && ($urandom_range(0, 5) == 0);
      step(a, b, c, d, we, wm, ld, pc, md);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 80'(exp_q.size()), 80'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
